// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if
// Bundles the request/operand/result signals of the nibble-serial adder.
//   start      : request to begin an addition (master -> slave)
//   A, B       : operands, 4*NIBBLES bits each (master -> slave)
//   busy       : operation in progress (slave -> master)
//   done       : one-cycle pulse, Sum first valid (slave -> master)
//   Sum        : registered result, MSB is the final carry (slave -> master)
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic [4*NIBBLES-1:0]   A;
    logic [4*NIBBLES-1:0]   B;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES:0]     Sum;

    modport master (
        output start, A, B,
        input  busy, done, Sum
    );

    modport slave (
        input  start, A, B,
        output busy, done, Sum
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two unsigned 4*NIBBLES-bit operands one nibble per clock through a
// single shared 4-bit adder. An accepted start captures the operands, NIBBLES
// RUN cycles ripple the carry from the least significant slice upward, and a
// single DONE cycle presents the new result with a done pulse.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_ctrl_if (start, A, B in;
//           busy, done, Sum out)
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, b_reg, work_reg;
    logic [W-1:0]       work_next;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [W:0]         sum_reg;

    logic               accept;
    logic               run_step;
    logic               last_step;

    logic [3:0]         a_slice [NIBBLES];
    logic [3:0]         b_slice [NIBBLES];
    logic [3:0]         a_sel, b_sel;
    logic [4:0]         slice_sum;

    // Slice views of the captured operands feeding the shared adder mux.
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[gi*4 +: 4];
            assign b_slice[gi] = b_reg[gi*4 +: 4];
            // Only the slice addressed by idx takes the adder output.
            assign work_next[gi*4 +: 4] = (run_step && (idx_reg == IDX_W'(gi)))
                                          ? slice_sum[3:0]
                                          : work_reg[gi*4 +: 4];
        end
    endgenerate

    assign a_sel     = a_slice[idx_reg];
    assign b_sel     = b_slice[idx_reg];
    assign slice_sum = {1'b0, a_sel} + {1'b0, b_sel} + {4'b0000, carry_reg};

    assign accept    = (state_reg == IDLE) && bus.start;
    assign run_step  = (state_reg == RUN);
    assign last_step = run_step && (idx_reg == LAST_IDX);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            if (accept) begin
                a_reg     <= bus.A;
                b_reg     <= bus.B;
                carry_reg <= 1'b0;
                idx_reg   <= '0;
            end else if (run_step) begin
                work_reg  <= work_next;
                carry_reg <= slice_sum[4];
                idx_reg   <= idx_reg + 1'b1;
            end
            // The final slice and carry are folded in directly so Sum is
            // valid in the same cycle that DONE is entered.
            if (last_step) begin
                sum_reg <= {slice_sum[4], work_next};
            end
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);
    assign bus.Sum  = sum_reg;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
// Directed and randomized operations checked against plain arithmetic:
// expected Sum is A+B, busy spans NIBBLES+1 cycles after acceptance,
// done fires in the last of them, Sum holds otherwise.
module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [W:0] model_sum;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One addition: start is presented with the operands, accepted at the
    // next edge; operand inputs are scrambled afterwards to show they are
    // ignored. keep_start leaves start high so the next call is back-to-back.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_start);
        logic [W:0] exp_sum;
        exp_sum   = {1'b0, a} + {1'b0, b};
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = keep_start;
        for (int c = 0; c <= N; c++) begin
            chk("busy", (W+1)'(bus.busy), (W+1)'(1'b1));
            chk("done", (W+1)'(bus.done), (W+1)'(c == N));
            chk("sum", bus.Sum, (c == N) ? exp_sum : model_sum);
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            tick();
        end
        model_sum = exp_sum;
        chk("idle_busy", (W+1)'(bus.busy), '0);
        chk("idle_done", (W+1)'(bus.done), '0);
        chk("idle_sum", bus.Sum, model_sum);
        $display("op A=%h B=%h expect Sum=%h got %h", a, b, exp_sum, bus.Sum);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst_n     = 1'b0;
        model_sum = '0;
        tick();
        tick();
        chk("rst_busy", (W+1)'(bus.busy), '0);
        chk("rst_done", (W+1)'(bus.done), '0);
        chk("rst_sum", bus.Sum, '0);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        do_op(16'h0005, 16'h0005, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b0);
        do_op(16'h0FFF, 16'h0001, 1'b0);
        do_op(16'h000F, 16'h000F, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b0);

        // Idle with start low: nothing moves
        for (int i = 0; i < 3; i++) begin
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            tick();
            chk("hold_busy", (W+1)'(bus.busy), '0);
            chk("hold_sum", bus.Sum, model_sum);
        end

        // Randomized operations
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), 1'b0);
        end

        // start held high continuously: accepts back-to-back every N+2 cycles
        for (int i = 0; i < 5; i++) begin
            do_op(W'($urandom), W'($urandom), (i != 4));
        end

        // Reset during the second RUN cycle of 0x1234+0x4321
        bus.start = 1'b1;
        bus.A     = 16'h1234;
        bus.B     = 16'h4321;
        tick();
        bus.start = 1'b0;
        tick();
        chk("pre_rst_busy", (W+1)'(bus.busy), (W+1)'(1'b1));
        rst_n = 1'b0;
        #1;
        model_sum = '0;
        chk("async_busy", (W+1)'(bus.busy), '0);
        chk("async_done", (W+1)'(bus.done), '0);
        chk("async_sum", bus.Sum, '0);
        for (int i = 0; i < N + 2; i++) begin
            tick();
            chk("rst_nodone", (W+1)'(bus.done), '0);
        end
        rst_n = 1'b1;
        do_op(16'h1234, 16'h4321, 1'b0);
        chk("after_rst_sum", bus.Sum, 17'h05555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
